// File: rtl/dac_req_arbiter_pkg.sv
// Shared constants for the DAC request arbiter: FSM state encodings and
// the counter sizing helper.
package dac_req_arbiter_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LAUNCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    // Bits needed to count 0 .. max(a,b)-1 (at least one bit).
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = 1;
        while ((1 << w) < m) w++;
        return w;
    endfunction

endpackage

// File: rtl/dac_req_arbiter_if.sv
// Requester handshake plus serializer launch bus. The slave modport is the
// arbiter; the master modport is the sample sources together with the serializer.
interface dac_req_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 12
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    dac_start;
    logic [DATA_W-1:0]       dac_data;
    logic                    dac_busy;

    modport master (
        output req_valid, req_data, dac_busy,
        input  req_ready, dac_start, dac_data
    );

    modport slave (
        input  req_valid, req_data, dac_busy,
        output req_ready, dac_start, dac_data
    );
endinterface

// File: rtl/dac_req_arbiter_rr_arbiter.sv
// Combinational winner selection. Round robin from ptr by default;
// define DAC_ARB_FIXED_PRIO_EN for lowest-index-wins with no pointer input.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
`ifndef DAC_ARB_FIXED_PRIO_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    output logic             win_any,
    output logic [IDX_W-1:0] win_idx,
    output logic [N_REQ-1:0] win_onehot
);

    always_comb begin
        int idx;
        idx        = 0;
        win_any    = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
`ifdef DAC_ARB_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_any = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
`else
        // Scan backwards so the candidate closest to ptr is written last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req_valid[idx]) begin
                win_any = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
`endif
        if (win_any) win_onehot[win_idx] = 1'b1;
    end

endmodule

// File: rtl/dac_req_arbiter.sv
// Shares one SPI DAC serializer between N_REQ sample producers, one frame per grant,
// with busy supervision and an inter-frame gap. DAC_ARB_FIXED_PRIO_EN selects fixed priority.
//
//  state     | meaning
//  IDLE      | waiting for any req_valid; accepts the winner this cycle
//  LAUNCH    | dac_start pulse, counter cleared
//  WAIT_BUSY | waiting for serializer busy, bounded by TIMEOUT_CYC
//  WAIT_DONE | frame in progress until busy falls
//  GAP       | enforced idle time before the next grant
module dac_req_arbiter
    import dac_req_arbiter_pkg::*;
#(
    parameter  int N_REQ       = 4,
    parameter  int DATA_W      = 12,
    parameter  int GAP_CYC     = 4,
    parameter  int TIMEOUT_CYC = 8,
    localparam int IDX_W       = $clog2(N_REQ)
) (
    input  logic               clk_in,
    input  logic               rst,
    dac_req_arbiter_if.slave   bus,
    output logic [IDX_W-1:0]   grant_id,
    output logic               active,
    output logic               err_timeout,
    input  logic               err_clr
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYC, GAP_CYC);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dac_data_q, dac_data_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic              err_q, err_d;

    logic              win_any;
    logic [IDX_W-1:0]  win_idx;
    logic [N_REQ-1:0]  win_onehot;

`ifndef DAC_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]  ptr_q, ptr_d;
`endif

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_valid  (bus.req_valid),
`ifndef DAC_ARB_FIXED_PRIO_EN
        .ptr        (ptr_q),
`endif
        .win_any    (win_any),
        .win_idx    (win_idx),
        .win_onehot (win_onehot)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dac_data_d = dac_data_q;
        grant_id_d = grant_id_q;
        // A timeout set below overrides this clear.
        err_d      = err_clr ? 1'b0 : err_q;
`ifndef DAC_ARB_FIXED_PRIO_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    dac_data_d = bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
                    grant_id_d = win_idx;
`ifndef DAC_ARB_FIXED_PRIO_EN
                    ptr_d      = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
`endif
                    state_d    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.dac_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.dac_busy) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // GAP_CYC of 0 still spends one cycle here, same as GAP_CYC of 1.
                if (cnt_q == GAP_LAST) state_d = ST_IDLE;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dac_data_q <= '0;
            grant_id_q <= '0;
            err_q      <= 1'b0;
`ifndef DAC_ARB_FIXED_PRIO_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dac_data_q <= dac_data_d;
            grant_id_q <= grant_id_d;
            err_q      <= err_d;
`ifndef DAC_ARB_FIXED_PRIO_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE && !rst) ? win_onehot : '0;
    assign bus.dac_start = (state_q == ST_LAUNCH);
    assign bus.dac_data  = dac_data_q;
    assign grant_id      = grant_id_q;
    assign active        = (state_q != ST_IDLE);
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_dac_req_arbiter.sv
// Scoreboard bench for dac_req_arbiter: stimulus queues expected grants,
// a monitor checks every ready pulse and dac_start against them.
module tb_dac_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 12;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       err_clr = 1'b0;
    logic [1:0] grant_id;
    logic       active;
    logic       err_timeout;

    dac_req_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus();

    dac_req_arbiter #(.N_REQ(N), .DATA_W(DW), .GAP_CYC(4), .TIMEOUT_CYC(8)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .bus         (bus),
        .grant_id    (grant_id),
        .active      (active),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          idx;
        logic [11:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc_cyc = -100;
    int          last_idx = 0;
    logic [11:0] last_data = '0;
    bit          acc_pend = 0;
    int          fall_cyc = 0;
    bit          has_fall = 0;
    bit          ser_mode = 1;
    int          ready_pulses[N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    // Serializer model: busy rises 2 cycles after dac_start and lasts 16 cycles.
    initial begin
        bus.dac_busy = 1'b0;
        forever begin
            @(negedge clk_in);
            if (bus.dac_start && ser_mode) begin
                @(posedge clk_in);
                @(posedge clk_in);
                #1 bus.dac_busy = 1'b1;
                repeat (16) @(posedge clk_in);
                #1 bus.dac_busy = 1'b0;
                if (active) begin
                    fall_cyc = cyc;
                    has_fall = 1;
                end
            end
        end
    end

    // Monitor
    initial begin
        int   cur;
        exp_t e;
        for (int i = 0; i < N; i++) ready_pulses[i] = 0;
        forever begin
            @(negedge clk_in);
            if (bus.req_ready != '0) begin
                cur = 0;
                for (int i = 0; i < N; i++) if (bus.req_ready[i]) cur = i;
                ready_pulses[cur]++;
                chk("ready_onehot", 32'($onehot(bus.req_ready)), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: requester %0d accepted, none expected (cycle %0d)", cur, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_idx", cur, e.idx);
                    chk("grant_data", bus.req_data[cur*DW +: DW], e.data);
                    if (has_fall) begin
                        chk("gap_len", cyc - fall_cyc, 5);
                        has_fall = 0;
                    end
                    last_data = e.data;
                    last_idx  = e.idx;
                end
                last_acc_cyc = cyc;
                acc_pend = 1;
            end
            if (bus.dac_start) begin
                if (!acc_pend) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_start: dac_start without pending accept (cycle %0d)", cyc);
                end else begin
                    chk("start_latency", cyc, last_acc_cyc + 1);
                    chk("start_data", bus.dac_data, last_data);
                    chk("start_grant_id", grant_id, last_idx);
                end
                acc_pend = 0;
            end
            if (bus.dac_busy && active) chk("data_stable", bus.dac_data, last_data);
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic tick_to(input int c);
        do begin
            @(posedge clk_in);
            #1;
        end while (cyc < c);
    endtask

    task automatic at_neg(input int c);
        do @(negedge clk_in); while (cyc < c);
    endtask

    task automatic set_req(input int i, input logic [11:0] d);
        bus.req_data[i*DW +: DW] = d;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic wait_q_size(input int n);
        int k = 0;
        while (exp_q.size() > n && k < 500) begin
            @(negedge clk_in);
            #1;
            k++;
        end
        chk("queue_level", exp_q.size(), n);
    endtask

    task automatic wait_start(output int s);
        int k = 0;
        do begin
            @(negedge clk_in);
            k++;
        end while (!bus.dac_start && k < 50);
        chk("start_seen", bus.dac_start, 1);
        s = cyc;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk_in);
            k++;
        end while (active && k < 300);
        chk("idle_reached", active, 0);
        has_fall = 0;
    endtask

    task automatic pulse_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_start"}, bus.dac_start, 0);
        chk({tag, "_ready"}, bus.req_ready, 0);
        chk({tag, "_data"}, bus.dac_data, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_err"}, err_timeout, 0);
    endtask

    initial begin
        int s;
        int r1_before;
        bus.req_valid = '0;
        bus.req_data  = '0;

        // 1: reset and idle
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk_all_zero("reset");
        tick();
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk_in);
            chk("idle_active", active, 0);
            chk("idle_start", bus.dac_start, 0);
            chk("idle_ready", bus.req_ready, 0);
        end

        // 2: single requester, two back-to-back samples
        tick();
        exp_q.push_back('{2, 12'hABC});
        exp_q.push_back('{2, 12'h123});
        set_req(2, 12'hABC);
        wait_q_size(1);
        tick();
        bus.req_data[2*DW +: DW] = 12'h123;
        wait_q_size(0);
        tick();
        bus.req_valid = '0;
        wait_idle();

        // 3: all requesters continuously valid from a fresh pointer
        pulse_reset();
`ifdef DAC_ARB_FIXED_PRIO_EN
        exp_q.push_back('{0, 12'h100});
        exp_q.push_back('{0, 12'h100});
        exp_q.push_back('{0, 12'h100});
`else
        exp_q.push_back('{0, 12'h100});
        exp_q.push_back('{1, 12'h101});
        exp_q.push_back('{2, 12'h102});
        exp_q.push_back('{3, 12'h103});
        exp_q.push_back('{0, 12'h100});
`endif
        for (int i = 0; i < N; i++) set_req(i, 12'(12'h100 + i));
        wait_q_size(0);
        tick();
        bus.req_valid = '0;
        wait_idle();

        // 4: serializer never raises busy
        ser_mode = 0;
        tick();
        exp_q.push_back('{3, 12'h7F0});
        set_req(3, 12'h7F0);
        wait_start(s);
        tick();
        bus.req_valid = '0;
        at_neg(s + 7);
        chk("timeout_early", err_timeout, 0);
        at_neg(s + 9);
        chk("timeout_set", err_timeout, 1);
        chk("timeout_continues", active, 1);
        wait_idle();
        chk("timeout_sticky", err_timeout, 1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk_in);
        chk("timeout_cleared", err_timeout, 0);
        tick();
        exp_q.push_back('{3, 12'h7F1});
        set_req(3, 12'h7F1);
        wait_start(s);
        tick();
        bus.req_valid = '0;
        tick_to(s + 8);
        err_clr = 1'b1;
        tick_to(s + 9);
        err_clr = 1'b0;
        at_neg(s + 9);
        chk("timeout_set_beats_clr", err_timeout, 1);
        wait_idle();
        ser_mode = 1;

        // 5: reset during WAIT_DONE
        tick();
        exp_q.push_back('{1, 12'h5A5});
        set_req(1, 12'h5A5);
        wait_start(s);
        tick();
        bus.req_valid = '0;
        tick_to(s + 4);
        chk("busy_before_reset", bus.dac_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk_in);
        chk_all_zero("midreset");
        // busy is still high from the abandoned frame; arbitration must proceed
        tick();
        exp_q.push_back('{0, 12'h100});
        for (int i = 0; i < N; i++) set_req(i, 12'(12'h100 + i));
        wait_q_size(0);
        tick();
        bus.req_valid = '0;
        wait_idle();

        // 6: requester 1 withdraws while another frame is busy
        r1_before = ready_pulses[1];
        tick();
        exp_q.push_back('{0, 12'h0A0});
        set_req(0, 12'h0A0);
        wait_start(s);
        tick();
        bus.req_valid = '0;
        tick_to(s + 5);
        set_req(1, 12'h111);
        tick_to(s + 10);
        bus.req_valid = '0;
        wait_idle();
        repeat (5) @(negedge clk_in);
        chk("req1_never_granted", ready_pulses[1] - r1_before, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
